// File: rtl/execute_mc.sv
// Multi-cycle execute stage: forwarding muxes, single-cycle ALU, iterative shift-add
// multiplier that stalls ID/EX, NVZ flag register and the EX/MEM pipeline register.
module execute_mc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iValid,
  input  logic              iFlush,
  output logic              oStall,
  input  logic [4:0]        iAluOp,
  input  logic              iAluUseImm,
  input  logic [DATA_W-1:0] iData1,
  input  logic [DATA_W-1:0] iData2,
  input  logic [DATA_W-1:0] iImm,
  input  logic [1:0]        iFwdA,
  input  logic [1:0]        iFwdB,
  input  logic [DATA_W-1:0] iMemFwdData,
  input  logic [DATA_W-1:0] iWbFwdData,
  input  logic              iAlutoReg,
  input  logic              iMemtoReg,
  input  logic              iBustoReg,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic [REG_W-1:0]  iDest,
  output logic              oValid,
  output logic [DATA_W-1:0] oAluOut,
  output logic [DATA_W-1:0] oData2,
  output logic [2:0]        oNVZ,
  output logic              oAlutoReg,
  output logic              oMemtoReg,
  output logic              oBustoReg,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [REG_W-1:0]  oDest
);

  localparam int unsigned Msb  = DATA_W - 1;
  localparam int unsigned ShW  = $clog2(DATA_W);
  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] op_a, fwd_b, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v, alu_flag;
  logic [ShW-1:0]    shamt;
  logic              is_mul, accept, mul_last;
  logic [4:0]        ctrl_in, ctrl_q, pend_ctrl_q;
  logic [REG_W-1:0]  pend_dest_q;
  logic [DATA_W-1:0] pend_data2_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_step;
  logic [CntW-1:0]   cnt_q;

  always_comb begin
    unique case (iFwdA)
      2'b01:   op_a = iMemFwdData;
      2'b10:   op_a = iWbFwdData;
      default: op_a = iData1;
    endcase
    unique case (iFwdB)
      2'b01:   fwd_b = iMemFwdData;
      2'b10:   fwd_b = iWbFwdData;
      default: fwd_b = iData2;
    endcase
    op_b = iAluUseImm ? iImm : fwd_b;
  end

  assign shamt   = op_b[ShW-1:0];
  assign is_mul  = (iAluOp == 5'd8);
  assign accept  = iValid && !oStall && !iFlush;
  assign ctrl_in = {iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite};

  // Opcode 8 is resolved by the multiplier; it falls into the zero/no-flag default here.
  always_comb begin
    alu_res  = '0;
    alu_v    = 1'b0;
    alu_flag = 1'b1;
    case (iAluOp)
      5'd0: begin
        alu_res = op_a + op_b;
        alu_v   = (op_a[Msb] == op_b[Msb]) && (alu_res[Msb] != op_a[Msb]);
      end
      5'd1: begin
        alu_res = op_a - op_b;
        alu_v   = (op_a[Msb] != op_b[Msb]) && (alu_res[Msb] != op_a[Msb]);
      end
      5'd2:    alu_res = op_a & op_b;
      5'd3:    alu_res = op_a | op_b;
      5'd4:    alu_res = op_a ^ op_b;
      5'd5:    alu_res = op_a << shamt;
      5'd6:    alu_res = op_a >> shamt;
      5'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      5'd9: begin
        alu_res  = op_b;
        alu_flag = 1'b0;
      end
      default: alu_flag = 1'b0;
    endcase
  end

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mul_last = (cnt_q == CntW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && is_mul)   state_d = StBusy;
      StBusy: if (iFlush || mul_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    oStall = (state_q == StBusy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oValid       <= 1'b0;
      oAluOut      <= '0;
      oData2       <= '0;
      oNVZ         <= 3'b000;
      oDest        <= '0;
      ctrl_q       <= '0;
      pend_ctrl_q  <= '0;
      pend_dest_q  <= '0;
      pend_data2_q <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      // Every edge writes a bubble unless a result is produced below.
      oValid <= 1'b0;
      ctrl_q <= '0;
      if (state_q == StBusy) begin
        if (!iFlush) begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (mul_last) begin
            oValid  <= 1'b1;
            oAluOut <= acc_step;
            oData2  <= pend_data2_q;
            oDest   <= pend_dest_q;
            ctrl_q  <= pend_ctrl_q;
            oNVZ    <= {acc_step[Msb], 1'b0, (acc_step == '0)};
          end
        end
      end else if (accept) begin
        if (is_mul) begin
          mcand_q      <= op_a;
          mplier_q     <= op_b;
          acc_q        <= '0;
          cnt_q        <= '0;
          pend_ctrl_q  <= ctrl_in;
          pend_dest_q  <= iDest;
          pend_data2_q <= fwd_b;
        end else begin
          oValid  <= 1'b1;
          oAluOut <= alu_res;
          oData2  <= fwd_b;
          oDest   <= iDest;
          ctrl_q  <= ctrl_in;
          if (alu_flag) oNVZ <= {alu_res[Msb], alu_v, (alu_res == '0)};
        end
      end
    end
  end

  assign {oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite} = ctrl_q;

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
Parametrised multi-cycle execute stage for the pipelined CPU. It sits between the ID/EX and EX/MEM boundaries and carries forwarding from both the EX/MEM and WB stages, a valid/stall/flush handshake, and an iterative shift-add multiplier that stalls upstream while it runs. The ALU, NVZ flag register and EX/MEM pipeline register are internal. Invalid or flushed slots become bubbles with all control bits forced to 0.

Parameters:
DATA_W, 16, datapath width in bits (range 4..64)
REG_W, 4, register-specifier width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
iValid  in  1  ID/EX holds a real instruction
iFlush  in  1  kill the current slot and any in-flight MUL
oStall  out  1  hold ID/EX; combinational, high while the MUL is BUSY
iAluOp  in  5  operation code
iAluUseImm  in  1  operand B = iImm
iData1, iData2  in  DATA_W  register-file operands
iImm  in  DATA_W  sign-extended immediate
iFwdA, iFwdB  in  2  operand source: 00 regfile, 01 iMemFwdData, 10 iWbFwdData, 11 regfile
iMemFwdData, iWbFwdData  in  DATA_W  forwarded values
iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite  in  1 each  downstream controls
iDest  in  REG_W  destination register
oValid  out  1  EX/MEM holds a real result
oAluOut  out  DATA_W  result
oData2  out  DATA_W  store data (forwarded B before the immediate mux)
oNVZ  out  3  flags {N,V,Z}
oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite  out  1 each  pipelined controls
oDest  out  REG_W  pipelined destination

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount = B[log2(DATA_W)-1:0]
  - 8 MUL: low DATA_W bits of the product, unsigned
  - 9 PASSB
  - All other codes give result 0 and leave flags unchanged.
- Operand A = fwd-mux(iFwdA). fwdB = fwd-mux(iFwdB). Operand B = iAluUseImm ? iImm : fwdB.
- Wrap-around: ADD and SUB arithmetic is modulo 2^DATA_W.
- Overflow: V = signed overflow for ADD/SUB. V is cleared by AND, OR, XOR, MUL and the shifts.
- Flags: N = result MSB, Z = (result == 0). Flags update for opcodes 0–8 only, and only when the result is written valid. Otherwise oNVZ holds.
- Accept: an instruction is accepted at a rising edge when iValid && !oStall && !iFlush.
- Reset: on rst, every output and internal register becomes 0, oNVZ = 000, and the FSM goes to IDLE. This applies mid-MUL as well; rst has priority over everything.
- FSM states: IDLE, BUSY.
- IDLE, non-MUL accept:
  - Result, fwdB, controls and iDest register at that edge.
  - oValid = 1 the next cycle, giving latency 1.
- IDLE, MUL accept:
  - A, B, controls and iDest latch at that edge; the accumulator and counter clear; the FSM goes to BUSY.
  - oValid = 0 the next cycle.
- BUSY:
  - Each cycle: if multiplier LSB = 1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
  - oStall = 1 in every BUSY cycle.
  - oValid = 0 on each edge that leaves the FSM in BUSY.
  - On the edge ending the cycle with cnt == DATA_W-1: the final accumulator registers to oAluOut, oValid = 1, flags update, and the FSM returns to IDLE.
  - Total: DATA_W BUSY cycles. The result is visible DATA_W+1 cycles after the accept edge.
- Held instruction: upstream holds the next instruction and it is accepted once oStall is low. Its forward selects are evaluated at acceptance.
- Not-accepted slot: when !iValid, or on a stalled edge, the edge writes a bubble: oValid = 0, all control outputs = 0. oAluOut, oData2 and oDest may hold. oNVZ holds.
- iFlush: has priority over accept. The next cycle oValid = 0 and controls = 0. If BUSY, the FSM returns to IDLE and oStall drops the next cycle; no flag update occurs and no result is produced.

Test Plan:
- ADD, A = 0x7FFF, B = 0x0001, iValid = 1 -> next cycle oValid = 1, oAluOut = 0x8000, oNVZ = 110.
- MUL, 0x0003 × 0x0005 (DATA_W = 16) -> oStall high 16 cycles, oValid = 0 throughout; oAluOut = 0x000F with oValid = 1 on cycle 17; the held next ADD is accepted after that.
- SUB, iFwdA = 01 (iMemFwdData = 0x1234), iFwdB = 10 (iWbFwdData = 0x0001) -> oAluOut = 0x1233, oData2 = 0x0001. Repeat with iAluUseImm = 1, iImm = 0x0004 -> oAluOut = 0x1230, oData2 = 0x0001.
- MUL accepted, iFlush pulsed on BUSY cycle 5 -> oStall low the next cycle, no oValid pulse, oNVZ unchanged, controls 0.
- rst asserted during MUL BUSY with iMemWrite latched -> next cycle all outputs 0, oStall = 0, oNVZ = 000.
- SUB 0x00AA − 0x00AA -> oNVZ = 001. Then AND 0xFFFF & 0x8000 -> oNVZ = 100. Then opcode 31 -> oAluOut = 0, oNVZ stays 100.
